// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl: majority-vote tap stepper with lock tracking driving a one-hot delay-line enable bus
module delay_tap_ctrl #(
    parameter int N_TAPS        = 512,
    parameter int TAP_W         = 9,
    parameter int INIT_TAP      = 256,
    parameter int SETTLE_CYCLES = 8,
    parameter int AVG_LOG2      = 4,
    parameter int LOCK_REV      = 4,
    parameter int LOSS_STEPS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_start,
    input  logic              cal_stop,
    input  logic              load,
    input  logic [TAP_W-1:0]  load_tap,
    input  logic              phase_vld,
    input  logic              phase_early,
    output logic [N_TAPS-1:0] en,
    output logic [TAP_W-1:0]  tap,
    output logic              busy,
    output logic              locked,
    output logic              err
);
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int RV_W = $clog2(LOCK_REV + 1);
    localparam int LS_W = $clog2(LOSS_STEPS + 1);
    localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(N_TAPS - 1);
    localparam logic [TAP_W-1:0] RST_TAP = TAP_W'(INIT_TAP);
    localparam logic [N_TAPS-1:0] ONE = N_TAPS'(1);
    localparam logic [AVG_LOG2:0] HALF = (AVG_LOG2 + 1)'(2 ** (AVG_LOG2 - 1));

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, STEP} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

    state_t             state_q, state_d;
    dir_t               last_dir_q, last_dir_d, new_dir;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [N_TAPS-1:0]  en_q, en_d;
    logic               busy_q, busy_d, locked_q, locked_d, err_q, err_d;
    logic [SC_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [AVG_LOG2:0]  early_cnt_q, early_cnt_d;
    logic [AVG_LOG2-1:0] vld_cnt_q, vld_cnt_d;
    logic [RV_W-1:0]    rev_cnt_q, rev_cnt_d;
    logic [LS_W-1:0]    loss_cnt_q, loss_cnt_d;
    logic               up_v, dn_v, tie, rev, end_hit;

    always_comb begin
        up_v = early_cnt_q > HALF;
        dn_v = early_cnt_q < HALF;
        tie = !up_v && !dn_v;
        new_dir = up_v ? D_UP : D_DN;
        // a tie is treated like a reversal: the comparator is sitting on the edge
        rev = tie || (last_dir_q != D_NONE && new_dir != last_dir_q);
        end_hit = (up_v && tap_q == MAX_TAP) || (dn_v && tap_q == '0);
        state_d = state_q;
        last_dir_d = last_dir_q;
        tap_d = tap_q;
        locked_d = locked_q;
        err_d = err_q;
        settle_cnt_d = settle_cnt_q;
        early_cnt_d = early_cnt_q;
        vld_cnt_d = vld_cnt_q;
        rev_cnt_d = rev_cnt_q;
        loss_cnt_d = loss_cnt_q;
        if (load) begin
            tap_d = (load_tap > MAX_TAP) ? MAX_TAP : load_tap;
            state_d = IDLE;
            locked_d = 1'b0;
            err_d = 1'b0;
            last_dir_d = D_NONE;
            settle_cnt_d = '0;
            early_cnt_d = '0;
            vld_cnt_d = '0;
            rev_cnt_d = '0;
            loss_cnt_d = '0;
        end else if (cal_stop) begin
            state_d = IDLE;
            locked_d = 1'b0;
            settle_cnt_d = '0;
            early_cnt_d = '0;
            vld_cnt_d = '0;
        end else if (cal_start && state_q == IDLE) begin
            state_d = SETTLE;
            err_d = 1'b0;
            last_dir_d = D_NONE;
            settle_cnt_d = '0;
            early_cnt_d = '0;
            vld_cnt_d = '0;
            rev_cnt_d = '0;
            loss_cnt_d = '0;
        end else begin
            case (state_q)
                SETTLE: begin
                    settle_cnt_d = (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) ? '0 : settle_cnt_q + SC_W'(1);
                    state_d = (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
                end
                SAMPLE: if (phase_vld) begin
                    early_cnt_d = early_cnt_q + {{AVG_LOG2{1'b0}}, phase_early};
                    vld_cnt_d = vld_cnt_q + AVG_LOG2'(1);
                    state_d = (&vld_cnt_q) ? STEP : SAMPLE;
                end
                STEP: begin
                    early_cnt_d = '0;
                    if (end_hit) begin
                        err_d = 1'b1;
                        locked_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        tap_d = up_v ? tap_q + TAP_W'(1) : dn_v ? tap_q - TAP_W'(1) : tap_q;
                        state_d = tie ? SAMPLE : SETTLE;
                        last_dir_d = tie ? last_dir_q : new_dir;
                        if (!locked_q) begin
                            rev_cnt_d = rev ? rev_cnt_q + RV_W'(1) : '0;
                            locked_d = rev && rev_cnt_q == RV_W'(LOCK_REV - 1);
                            loss_cnt_d = '0;
                        end else if (rev) begin
                            loss_cnt_d = '0;
                        end else if (loss_cnt_q == LS_W'(LOSS_STEPS - 1)) begin
                            locked_d = 1'b0;
                            rev_cnt_d = '0;
                            loss_cnt_d = '0;
                        end else begin
                            loss_cnt_d = loss_cnt_q + LS_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        en_d = ONE << tap_d;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_dir_q <= D_NONE;
            tap_q <= RST_TAP;
            en_q <= ONE << RST_TAP;
            busy_q <= 1'b0;
            locked_q <= 1'b0;
            err_q <= 1'b0;
            settle_cnt_q <= '0;
            early_cnt_q <= '0;
            vld_cnt_q <= '0;
            rev_cnt_q <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_dir_q <= last_dir_d;
            tap_q <= tap_d;
            en_q <= en_d;
            busy_q <= busy_d;
            locked_q <= locked_d;
            err_q <= err_d;
            settle_cnt_q <= settle_cnt_d;
            early_cnt_q <= early_cnt_d;
            vld_cnt_q <= vld_cnt_d;
            rev_cnt_q <= rev_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign en = en_q;
    assign tap = tap_q;
    assign busy = busy_q;
    assign locked = locked_q;
    assign err = err_q;
endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb_delay_tap_ctrl: randomized vote-level reference model checked every cycle against delay_tap_ctrl
module tb_delay_tap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1, cal_start = 1'b0, cal_stop = 1'b0, load = 1'b0;
    logic phase_vld = 1'b0, phase_early = 1'b0;
    logic [8:0] load_tap = '0;
    logic [8:0] tap;
    logic [511:0] en;
    logic busy, locked, err;
    logic [511:0] one512 = 512'd1;
    int n_tests = 0, n_fail = 0;
    int m_tap, m_last, m_rev, m_loss;
    bit m_locked, m_err, m_busy;

    always #5 clk = ~clk;

    delay_tap_ctrl dut (
        .clk(clk), .rst(rst), .cal_start(cal_start), .cal_stop(cal_stop),
        .load(load), .load_tap(load_tap), .phase_vld(phase_vld), .phase_early(phase_early),
        .en(en), .tap(tap), .busy(busy), .locked(locked), .err(err)
    );

    task automatic m_reset();
        m_tap = 256; m_last = 0; m_rev = 0; m_loss = 0;
        m_locked = 0; m_err = 0; m_busy = 0;
    endtask

    // one vote resolved from the rules: majority of 16, +/-1 step, reversal/tie lock counting
    task automatic model_vote(input int e);
        int d;
        bit r;
        d = (e > 8) ? 1 : (e < 8) ? -1 : 0;
        if ((d == 1 && m_tap == 511) || (d == -1 && m_tap == 0)) begin
            m_err = 1; m_locked = 0; m_busy = 0;
            return;
        end
        m_tap += d;
        r = (d == 0) || (m_last != 0 && d != m_last);
        if (d != 0) m_last = d;
        if (!m_locked) begin
            m_rev = r ? m_rev + 1 : 0;
            if (m_rev >= 4) begin m_locked = 1; m_loss = 0; end
        end else if (r) m_loss = 0;
        else begin
            m_loss++;
            if (m_loss >= 8) begin m_locked = 0; m_rev = 0; m_loss = 0; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_tests++;
        if (tap !== 9'(m_tap) || en !== (one512 << m_tap) || busy !== m_busy || locked !== m_locked || err !== m_err) begin
            n_fail++;
            $display("FAIL cycle t=%0t: tap=%0d need %0d, en_ones=%0d en_at_tap=%b, busy=%b need %b, locked=%b need %b, err=%b need %b",
                     $time, tap, m_tap, $countones(en), en[m_tap[8:0]], busy, m_busy, locked, m_locked, err, m_err);
        end
    endtask

    task automatic settle();
        repeat (8) begin
            phase_vld = 1'($urandom);
            phase_early = 1'($urandom);
            tick();
        end
    endtask

    task automatic do_load(input int t);
        load = 1'b1; load_tap = 9'(t);
        m_tap = (t > 511) ? 511 : t;
        m_busy = 0; m_locked = 0; m_err = 0; m_rev = 0; m_loss = 0; m_last = 0;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        cal_start = 1'b1;
        m_busy = 1; m_err = 0; m_rev = 0; m_loss = 0; m_last = 0;
        tick();
        cal_start = 1'b0;
        settle();
    endtask

    task automatic vote(input int e, input int gap_pct);
        bit pat[16];
        bit tb;
        int k, prev, j;
        for (int i = 0; i < 16; i++) pat[i] = (i < e);
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tb = pat[i]; pat[i] = pat[j]; pat[j] = tb;
        end
        k = 0;
        for (int c = 0; c < 400 && k < 16; c++) begin
            phase_vld = ($urandom_range(99, 0) >= gap_pct);
            phase_early = phase_vld ? pat[k] : 1'($urandom);
            if (phase_vld) k++;
            tick();
        end
        n_tests++;
        if (k !== 16) begin
            n_fail++;
            $display("FAIL vote_samples: delivered %0d need 16", k);
        end
        phase_vld = 1'($urandom);
        phase_early = 1'($urandom);
        prev = m_tap;
        model_vote(e);
        tick();
        if (m_busy && m_tap != prev) settle();
    endtask

    task automatic test_reset();
        m_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (tap !== 9'd256 || en !== (one512 << 256) || busy !== 1'b0 || locked !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: tap=%0d busy=%b locked=%b err=%b en_ones=%0d, need 256/0/0/0/1", tap, busy, locked, err, $countones(en));
        end
    endtask

    task automatic test_track_up();
        do_start();
        vote(16, 0);
        n_tests++;
        if (tap !== 9'd257) begin n_fail++; $display("FAIL first_step: tap=%0d need 257", tap); end
        vote(16, 0);
        vote(16, 0);
        n_tests++;
        if (tap !== 9'd259 || locked !== 1'b0) begin
            n_fail++; $display("FAIL track_up: tap=%0d locked=%b need 259/0", tap, locked);
        end
        cal_stop = 1'b1; m_busy = 0; m_locked = 0;
        tick();
        cal_stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || tap !== 9'd259) begin
            n_fail++; $display("FAIL cal_stop: busy=%b tap=%0d need 0/259", busy, tap);
        end
    endtask

    task automatic test_end_stop();
        do_load(510);
        do_start();
        vote(16, 0);
        vote(16, 0);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || tap !== 9'd511) begin
            n_fail++; $display("FAIL end_stop_up: err=%b busy=%b tap=%0d need 1/0/511", err, busy, tap);
        end
        repeat (3) tick();
        cal_stop = 1'b1;
        tick();
        cal_stop = 1'b0;
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b need 1", err); end
        do_load(100);
        n_tests++;
        if (err !== 1'b0 || tap !== 9'd100) begin n_fail++; $display("FAIL load_clears_err: err=%b tap=%0d need 0/100", err, tap); end
        do_load(0);
        do_start();
        vote($urandom_range(7, 0), 30);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || tap !== 9'd0) begin
            n_fail++; $display("FAIL end_stop_down: err=%b busy=%b tap=%0d need 1/0/0", err, busy, tap);
        end
        do_start();
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL start_clears_err: err=%b busy=%b need 0/1", err, busy); end
        cal_stop = 1'b1; m_busy = 0; m_locked = 0;
        tick();
        cal_stop = 1'b0;
    endtask

    task automatic test_lock();
        do_load(300);
        do_start();
        for (int i = 0; i < 5; i++) begin
            vote((i % 2) ? $urandom_range(7, 0) : $urandom_range(16, 9), 20);
            n_tests++;
            if (locked !== (i == 4)) begin n_fail++; $display("FAIL lock_vote%0d: locked=%b need %b", i, locked, i == 4); end
        end
        n_tests++;
        if (tap !== 9'd301) begin n_fail++; $display("FAIL lock_toggle: tap=%0d need 301", tap); end
        for (int i = 0; i < 8; i++) begin
            vote($urandom_range(16, 9), 20);
            n_tests++;
            if (locked !== (i < 7)) begin n_fail++; $display("FAIL loss_vote%0d: locked=%b need %b", i, locked, i < 7); end
        end
    endtask

    task automatic test_tie();
        do_load(50);
        do_start();
        for (int i = 0; i < 4; i++) begin
            vote(8, 40);
            n_tests++;
            if (tap !== 9'd50 || busy !== 1'b1) begin n_fail++; $display("FAIL tie%0d: tap=%0d busy=%b need 50/1", i, tap, busy); end
        end
        n_tests++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL tie_lock: locked=%b need 1", locked); end
        vote(9, 40);
        vote(7, 40);
        n_tests++;
        if (tap !== 9'd50) begin n_fail++; $display("FAIL near_tie: tap=%0d need 50", tap); end
    endtask

    task automatic test_abort();
        do_load(200);
        do_start();
        repeat (5) begin
            phase_vld = 1'b1; phase_early = 1'($urandom);
            tick();
        end
        phase_vld = 1'b1;
        do_load(511);
        n_tests++;
        if (tap !== 9'd511 || busy !== 1'b0) begin n_fail++; $display("FAIL load_mid_sample: tap=%0d busy=%b need 511/0", tap, busy); end
        tick();
        cal_start = 1'b1; m_busy = 1; m_err = 0;
        tick();
        cal_start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        m_reset();
        tick();
        rst = 1'b0;
        n_tests++;
        if (tap !== 9'd256 || en !== (one512 << 256) || busy !== 1'b0 || locked !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_settle: tap=%0d busy=%b locked=%b err=%b need 256/0/0/0", tap, busy, locked, err);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; cal_stop = 1'b1; cal_start = 1'b1; load_tap = 9'd77;
        m_tap = 77; m_busy = 0; m_locked = 0; m_err = 0;
        tick();
        load = 1'b0;
        n_tests++;
        if (tap !== 9'd77 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_load: tap=%0d busy=%b need 77/0", tap, busy); end
        tick();
        cal_stop = 1'b0; cal_start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_stop: busy=%b need 0", busy); end
    endtask

    task automatic test_back_to_back();
        do_load($urandom_range(400, 100));
        do_start();
        for (int i = 0; i < 12 && m_busy; i++) vote($urandom_range(16, 0), $urandom_range(50, 0));
        n_tests++;
        if (tap !== 9'(m_tap) || locked !== m_locked) begin
            n_fail++; $display("FAIL back_to_back: tap=%0d locked=%b need %0d/%b", tap, locked, m_tap, m_locked);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_track_up();
        test_end_stop();
        test_lock();
        test_tie();
        test_abort();
        test_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
